// File: rtl/calc_ctrl_pkg.sv
// Shared state encoding and datapath widths for the nibble-serial accumulator.
// Imported by the controller top; no logic of its own.
package calc_ctrl_pkg;

   localparam int ACC_WIDTH    = 8;
   localparam int NIBBLE_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ADD_LO = 2'd1,
      ADD_HI = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchroniser plus stability counter for one active-low key.
// Press pulse lands 2 + DEBOUNCE_CYCLES edges after a clean press; releases emit nothing.
module key_debouncer #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_key_n,
   output logic o_press
);

   localparam int              CNT_W    = 20;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_q1;
   logic             sync_q2;
   logic             level_q;
   logic             press_q;
   logic [CNT_W-1:0] cnt_q;
   logic             differ;
   logic             accept;

   assign differ = (sync_q2 != level_q);
   // This sample is the DEBOUNCE_CYCLES-th consecutive one disagreeing with the accepted level.
   assign accept = differ && (cnt_q == CNT_LAST);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_q1 <= 1'b1;
         sync_q2 <= 1'b1;
      end else begin
         sync_q1 <= i_key_n;
         sync_q2 <= sync_q1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         level_q <= 1'b1;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         press_q <= accept && !sync_q2;
         if (!differ) begin
            cnt_q <= '0;
         end else if (accept) begin
            cnt_q   <= '0;
            level_q <= sync_q2;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign o_press = press_q;

endmodule

// File: rtl/ripple_carry_adder_4.sv
// Combinational 4-bit ripple-carry adder with carry in/out.
// Zero latency; no flow control.
module ripple_carry_adder_4 (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic       i_cin,
   output logic [3:0] o_sum,
   output logic       o_cout
);

   logic [4:0] carry;

   assign carry[0] = i_cin;

   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign o_sum[i]     = i_a[i] ^ i_b[i] ^ carry[i];
      assign carry[i + 1] = (i_a[i] & i_b[i]) | (carry[i] & (i_a[i] ^ i_b[i]));
   end

   assign o_cout = carry[4];

endmodule

// File: rtl/nibble_serial_accumulator_ctrl.sv
// 8-bit running-sum calculator reusing one 4-bit adder over two cycles (low then high nibble).
// Add result final 2 cycles after operand capture, o_done in the 3rd; presses while busy are dropped, clear aborts.
module nibble_serial_accumulator_ctrl
   import calc_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_key_add_n,
   input  logic                    i_key_clr_n,
   input  logic [NIBBLE_WIDTH-1:0] i_operand,
   output logic [ACC_WIDTH-1:0]    o_acc,
   output logic                    o_overflow,
   output logic                    o_busy,
   output logic                    o_done
);

   state_t                  state_q;
   state_t                  state_d;
   logic                    add_press;
   logic                    clr_press;
   logic [NIBBLE_WIDTH-1:0] operand_q;
   logic [ACC_WIDTH-1:0]    acc_q;
   logic                    carry_q;
   logic                    overflow_q;
   logic [NIBBLE_WIDTH-1:0] add_a;
   logic [NIBBLE_WIDTH-1:0] add_b;
   logic                    add_cin;
   logic [NIBBLE_WIDTH-1:0] add_sum;
   logic                    add_cout;

   key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_add (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_key_n (i_key_add_n),
      .o_press (add_press)
   );

   key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_clr (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_key_n (i_key_clr_n),
      .o_press (clr_press)
   );

   ripple_carry_adder_4 u_adder (
      .i_a    (add_a),
      .i_b    (add_b),
      .i_cin  (add_cin),
      .o_sum  (add_sum),
      .o_cout (add_cout)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Clear overrides everything, including a simultaneous add press.
   always_comb begin
      state_d = state_q;
      if (clr_press) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (add_press) state_d = ADD_LO;
            ADD_LO:  state_d = ADD_HI;
            ADD_HI:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      o_busy  = 1'b0;
      o_done  = 1'b0;
      case (state_q)
         ADD_LO: begin
            add_a  = acc_q[NIBBLE_WIDTH-1:0];
            add_b  = operand_q;
            o_busy = 1'b1;
         end
         ADD_HI: begin
            add_a   = acc_q[ACC_WIDTH-1:NIBBLE_WIDTH];
            add_cin = carry_q;
            o_busy  = 1'b1;
         end
         DONE:    o_done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         operand_q  <= '0;
         acc_q      <= '0;
         carry_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else if (clr_press) begin
         acc_q      <= '0;
         carry_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (add_press) operand_q <= i_operand;
            ADD_LO: begin
               acc_q[NIBBLE_WIDTH-1:0] <= add_sum;
               carry_q                 <= add_cout;
            end
            ADD_HI: begin
               acc_q[ACC_WIDTH-1:NIBBLE_WIDTH] <= add_sum;
               if (add_cout) overflow_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign o_acc      = acc_q;
   assign o_overflow = overflow_q;

endmodule

// File: tb/tb_nibble_serial_accumulator_ctrl.sv
// Bench for nibble_serial_accumulator_ctrl: directed scenarios plus random key traffic
// checked every cycle against a transaction-level model of debounce and add/clear.
module tb_nibble_serial_accumulator_ctrl;

   localparam int N = 4;

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b0;
   logic       key_add_n = 1'b1;
   logic       key_clr_n = 1'b1;
   logic [3:0] operand   = 4'h0;
   logic [7:0] acc;
   logic       ovf;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt = 0;
   int busy_cnt = 0;

   nibble_serial_accumulator_ctrl #(.DEBOUNCE_CYCLES(N)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_key_add_n (key_add_n),
      .i_key_clr_n (key_clr_n),
      .i_operand   (operand),
      .o_acc       (acc),
      .o_overflow  (ovf),
      .o_busy      (busy),
      .o_done      (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Key k (0 = add, 1 = clear): raw samples reach the stability check two edges late;
   // the accepted level flips once the last N checked samples all disagree with it.
   bit          pipe  [2][2];
   logic [31:0] seen  [2];
   bit          lvl   [2];
   bit          pulse [2];
   logic [7:0]  m_acc;
   logic [7:0]  m_mid;
   logic [7:0]  m_final;
   bit          m_ovf;
   bit          m_carry8;
   int          m_steps;   // cycles of the current add still to run: 3,2 busy; 1 done; 0 idle

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         pipe[k][0] = 1'b1;
         pipe[k][1] = 1'b1;
         seen[k]    = '1;
         lvl[k]     = 1'b1;
         pulse[k]   = 1'b0;
      end
      m_acc   = 8'h00;
      m_ovf   = 1'b0;
      m_steps = 0;
   endfunction

   function automatic void step_key(input int k, input bit raw);
      bit          s;
      logic [31:0] mask;
      mask       = (32'd1 << N) - 32'd1;
      s          = pipe[k][0];
      pipe[k][0] = pipe[k][1];
      pipe[k][1] = raw;
      seen[k]    = {seen[k][30:0], s};
      pulse[k]   = 1'b0;
      if ((seen[k] & mask) == (lvl[k] ? 32'd0 : mask)) begin
         lvl[k]   = s;
         pulse[k] = (s == 1'b0);
      end
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_reset();
      end else begin
         if (pulse[1]) begin
            m_acc   = 8'h00;
            m_ovf   = 1'b0;
            m_steps = 0;
         end else begin
            case (m_steps)
               0: if (pulse[0]) begin
                  int sum;
                  sum      = int'(m_acc) + int'(operand);
                  m_final  = 8'(sum % 256);
                  m_mid    = (m_acc & 8'hF0) | 8'(sum % 16);
                  m_carry8 = (sum > 255);
                  m_steps  = 3;
               end
               3: begin
                  m_acc   = m_mid;
                  m_steps = 2;
               end
               2: begin
                  m_acc = m_final;
                  if (m_carry8) m_ovf = 1'b1;
                  m_steps = 1;
               end
               default: m_steps = 0;
            endcase
         end
         step_key(0, key_add_n);
         step_key(1, key_clr_n);
      end
   end

   always @(negedge clk) begin
      chk("acc", 32'(acc), 32'(m_acc));
      chk("overflow", 32'(ovf), 32'(m_ovf));
      chk("busy", 32'(busy), 32'(m_steps >= 2));
      chk("done", 32'(done), 32'(m_steps == 1));
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1) busy_cnt++;
   end

   // ---------------- stimulus ----------------
   task automatic do_add(input logic [3:0] op, input string name);
      int d0;
      int b0;
      d0        = done_cnt;
      b0        = busy_cnt;
      operand   = op;
      key_add_n = 1'b0;
      repeat (10) @(negedge clk);
      key_add_n = 1'b1;
      repeat (12) @(negedge clk);
      chk({name, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
      chk({name, "_busy_cycles"}, 32'(busy_cnt - b0), 32'd2);
   endtask

   task automatic do_clear();
      key_clr_n = 1'b0;
      repeat (10) @(negedge clk);
      key_clr_n = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   initial begin
      int d0;
      int waited;

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("idle_acc", 32'(acc), 32'h00);
      chk("idle_ovf", 32'(ovf), 32'h0);
      chk("idle_done_total", 32'(done_cnt), 32'd0);

      do_add(4'h9, "add9_first");
      chk("acc_after_9", 32'(acc), 32'h09);
      do_add(4'h9, "add9_second");
      chk("acc_after_9_9", 32'(acc), 32'h12);

      do_clear();
      chk("acc_after_clear", 32'(acc), 32'h00);
      for (int i = 0; i < 16; i++) do_add(4'hF, "preload_f");
      do_add(4'hE, "preload_e");
      chk("acc_preload", 32'(acc), 32'hFE);
      chk("ovf_preload", 32'(ovf), 32'h0);
      do_add(4'h3, "wrap_add");
      chk("acc_wrap", 32'(acc), 32'h01);
      chk("ovf_wrap", 32'(ovf), 32'h1);
      do_add(4'h1, "sticky_add");
      chk("acc_sticky", 32'(acc), 32'h02);
      chk("ovf_sticky", 32'(ovf), 32'h1);

      // Bouncing press and release around a single stable low period.
      d0      = done_cnt;
      operand = 4'h7;
      for (int i = 0; i < 10; i++) begin
         key_add_n = ~key_add_n;
         repeat (2) @(negedge clk);
      end
      key_add_n = 1'b0;
      repeat (10) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         key_add_n = ~key_add_n;
         repeat (2) @(negedge clk);
      end
      key_add_n = 1'b1;
      repeat (14) @(negedge clk);
      chk("bounce_single_add", 32'(done_cnt - d0), 32'd1);
      chk("bounce_acc", 32'(acc), 32'h09);

      // Clear pulse lands two cycles after the add pulse, i.e. during ADD_HI.
      do_clear();
      do_add(4'hF, "pre_abort");
      chk("acc_pre_abort", 32'(acc), 32'h0F);
      d0        = done_cnt;
      operand   = 4'h1;
      key_add_n = 1'b0;
      repeat (2) @(negedge clk);
      key_clr_n = 1'b0;
      repeat (10) @(negedge clk);
      key_add_n = 1'b1;
      key_clr_n = 1'b1;
      repeat (14) @(negedge clk);
      chk("abort_acc", 32'(acc), 32'h00);
      chk("abort_ovf", 32'(ovf), 32'h0);
      chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

      // Add and clear pulses in the same cycle.
      do_add(4'h5, "pre_both");
      chk("acc_pre_both", 32'(acc), 32'h05);
      d0        = done_cnt;
      operand   = 4'h3;
      key_add_n = 1'b0;
      key_clr_n = 1'b0;
      repeat (10) @(negedge clk);
      key_add_n = 1'b1;
      key_clr_n = 1'b1;
      repeat (14) @(negedge clk);
      chk("both_acc", 32'(acc), 32'h00);
      chk("both_no_done", 32'(done_cnt - d0), 32'd0);

      // Random key traffic with a changing operand.
      for (int i = 0; i < 1200; i++) begin
         if ($urandom_range(0, 5) == 0)  key_add_n = ~key_add_n;
         if ($urandom_range(0, 19) == 0) key_clr_n = ~key_clr_n;
         operand = 4'($urandom_range(0, 15));
         @(negedge clk);
      end
      key_add_n = 1'b1;
      key_clr_n = 1'b1;
      repeat (30) @(negedge clk);

      // Asynchronous reset in the middle of ADD_LO.
      do_add(4'hA, "pre_reset");
      operand   = 4'h6;
      key_add_n = 1'b0;
      waited    = 0;
      while (busy !== 1'b1 && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      chk("reset_busy_wait_in_budget", 32'(waited < 40), 32'd1);
      key_add_n = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("reset_acc", 32'(acc), 32'h00);
      chk("reset_ovf", 32'(ovf), 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_done", 32'(done), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      do_add(4'h5, "post_reset");
      chk("acc_post_reset", 32'(acc), 32'h05);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
